// File: rtl/dts_pll_pkg.sv
// Shared types and helpers for the DTS clock PLL supervisor.
package dts_pll_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

    // One timer is shared by all states, so it must hold the largest count.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dts_sync2.sv
// Generic two-flop synchroniser for signals crossing into the local clock.
module dts_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync_q;

    // NOTE: the first stage has no reset; resetting it would add a reset path
    // into the metastable flop and gains nothing, since the second stage is cleared.
    always_ff @(posedge clk) begin
        meta <= d;
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= meta;
    end

    assign q = sync_q;

endmodule

// File: rtl/dts_pll_supervisor.sv
// Drives the DTS PLL reset, waits for a stable lock with timeout/retry and
// gates the downstream reset; runs only on the free-running refclk.
module dts_pll_supervisor
    import dts_pll_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             user_rst,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_lost_count
);

    localparam int TW = timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam logic [TW-1:0]    RST_LAST     = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]    STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          retry_inc, lost_inc;
    logic          lock_s;

    dts_sync2 #(.W(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_inc = 1'b0;
        lost_inc  = 1'b0;
        if (force_relock) begin
            state_d = RESET_PLL;
            timer_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABILIZE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        state_d   = RESET_PLL;
                        timer_d   = '0;
                        retry_inc = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d  = RESET_PLL;
                        timer_d  = '0;
                        lost_inc = 1'b1;
                    end
                end
                default: begin
                    state_d = RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= RESET_PLL;
            timer_q         <= '0;
            retry_count     <= '0;
            lock_lost_count <= '0;
            pll_rst         <= 1'b1;
            user_rst        <= 1'b1;
            ready           <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pll_rst  <= (state_d == RESET_PLL);
            ready    <= (state_d == RUN);
            user_rst <= (state_d != RUN);
            if (retry_inc && retry_count != CNT_MAX)
                retry_count <= retry_count + 1'b1;
            if (lost_inc && lock_lost_count != CNT_MAX)
                lock_lost_count <= lock_lost_count + 1'b1;
        end
    end

    assign state = state_q;

endmodule
